// File: rtl/fetch_redirect_unit_if.sv
// rtl/fetch_redirect_unit_if.sv - fetch, resolution and redirect signal bundle for fetch_redirect_unit
interface fetch_redirect_unit_if #(
  parameter int WORD_SIZE = 16
);
  logic                 stall;
  logic                 is_control;
  logic [WORD_SIZE-1:0] prediction;
  logic                 jump_resolved;
  logic [WORD_SIZE-1:0] jump_pc;
  logic [WORD_SIZE-1:0] jump_target;
  logic                 branch_resolved;
  logic [WORD_SIZE-1:0] branch_pc;
  logic [WORD_SIZE-1:0] branch_target;
  logic                 branch_taken;
  logic [WORD_SIZE-1:0] pc;
  logic                 flush;
  logic                 flush_ex;
  logic                 queue_full_stall;
  logic                 order_error;
  logic [15:0]          mispredict_count;

  modport master (
    output stall, is_control, prediction,
    output jump_resolved, jump_pc, jump_target,
    output branch_resolved, branch_pc, branch_target, branch_taken,
    input  pc, flush, flush_ex, queue_full_stall, order_error, mispredict_count
  );

  modport slave (
    input  stall, is_control, prediction,
    input  jump_resolved, jump_pc, jump_target,
    input  branch_resolved, branch_pc, branch_target, branch_taken,
    output pc, flush, flush_ex, queue_full_stall, order_error, mispredict_count
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - fetch PC sequencer with an in-flight prediction queue checked
// against ID jump and EX branch resolutions; mispredictions redirect fetch and flush.
module fetch_redirect_unit #(
  parameter int WORD_SIZE = 16,
  parameter int QDEPTH    = 4
) (
  input logic             clk,
  input logic             reset,
  fetch_redirect_unit_if.slave bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [WORD_SIZE-1:0] q_pc   [QDEPTH];
  logic [WORD_SIZE-1:0] q_pred [QDEPTH];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [CW-1:0]        count;

  logic [WORD_SIZE-1:0] pc_r;
  logic                 flush_r;
  logic                 flush_ex_r;
  logic                 order_error_r;
  logic [15:0]          mispredict_count_r;

  logic [WORD_SIZE-1:0] br_actual;
  logic                 br_hit;
  logic                 br_mis;
  logic [PW-1:0]        jump_idx;
  logic                 jump_live;
  logic                 j_hit;
  logic                 j_mis;
  logic                 order_fault;
  logic                 redirect;
  logic [CW-1:0]        pop_n;
  logic                 full_stall;
  logic                 advance;
  logic                 push;

  always_comb begin
    br_actual = bus.branch_taken ? bus.branch_target
                                 : bus.branch_pc + {{(WORD_SIZE-1){1'b0}}, 1'b1};
    br_hit    = bus.branch_resolved && (count != '0) && (q_pc[rd_ptr] == bus.branch_pc);
    br_mis    = br_hit && (br_actual != q_pred[rd_ptr]);
    // The jump is the entry just behind whatever the branch consumed this cycle.
    jump_idx  = rd_ptr + PW'(br_hit);
    jump_live = bus.jump_resolved && !br_mis;
    j_hit     = jump_live && (count > CW'(br_hit)) && (q_pc[jump_idx] == bus.jump_pc);
    j_mis     = j_hit && (bus.jump_target != q_pred[jump_idx]);

    order_fault = (bus.branch_resolved && !br_hit) || (jump_live && !j_hit);
    redirect    = br_mis || j_mis;
    pop_n       = CW'(br_hit) + CW'(j_hit);

    full_stall  = bus.is_control && (count == CW'(QDEPTH)) && (pop_n == '0);
    advance     = !redirect && !bus.stall && !full_stall;
    push        = advance && bus.is_control;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r               <= '0;
      rd_ptr             <= '0;
      wr_ptr             <= '0;
      count              <= '0;
      flush_r            <= 1'b0;
      flush_ex_r         <= 1'b0;
      order_error_r      <= 1'b0;
      mispredict_count_r <= '0;
    end else begin
      flush_r    <= redirect;
      flush_ex_r <= br_mis;
      if (order_fault) begin
        order_error_r <= 1'b1;
      end
      if (redirect) begin
        // Every entry younger than the mispredicted one is wrong-path, so the queue empties.
        pc_r   <= br_mis ? br_actual : bus.jump_target;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        if (mispredict_count_r != 16'hFFFF) begin
          mispredict_count_r <= mispredict_count_r + 16'd1;
        end
      end else begin
        rd_ptr <= rd_ptr + PW'(pop_n);
        wr_ptr <= wr_ptr + PW'(push);
        count  <= count - pop_n + CW'(push);
        if (advance) begin
          pc_r <= bus.prediction;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= pc_r;
      q_pred[wr_ptr] <= bus.prediction;
    end
  end

  assign bus.pc               = pc_r;
  assign bus.flush            = flush_r;
  assign bus.flush_ex         = flush_ex_r;
  assign bus.queue_full_stall = full_stall;
  assign bus.order_error      = order_error_r;
  assign bus.mispredict_count = mispredict_count_r;
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb/tb_fetch_redirect_unit.sv - self-checking bench for fetch_redirect_unit
module tb_fetch_redirect_unit;
  localparam int W  = 16;
  localparam int QD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_redirect_unit_if #(.WORD_SIZE(W)) bus ();
  fetch_redirect_unit #(.WORD_SIZE(W), .QDEPTH(QD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [W-1:0] cpc;
    logic [W-1:0] pred;
  } entry_t;

  typedef struct {
    logic         st;
    logic         ic;
    logic [W-1:0] pr;
    logic         br;
    logic [W-1:0] bpc;
    logic [W-1:0] btgt;
    logic         btk;
    logic         jr;
    logic [W-1:0] jpc;
    logic [W-1:0] jtgt;
    logic [W-1:0] e_pc;
    logic         e_fl;
    logic         e_flex;
    logic [15:0]  e_cnt;
  } vec_t;

  entry_t       mq[$];
  logic [W-1:0] m_pc;
  logic         m_flush, m_flush_ex, m_err;
  logic [15:0]  m_cnt;
  int checks = 0;
  int errors = 0;
  vec_t vt[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc = '0;
    m_flush = 1'b0;
    m_flush_ex = 1'b0;
    m_err = 1'b0;
    m_cnt = '0;
  endtask

  // Reference: the queue is an ordered list of predictions, resolutions must match its front.
  task automatic model_step(output bit exp_qfs);
    bit bmis, jmis, bpop, jpop;
    logic [W-1:0] act, tgt;
    int ji;
    bmis = 0; jmis = 0; bpop = 0; jpop = 0; tgt = '0;
    if (bus.branch_resolved) begin
      if (mq.size() > 0 && mq[0].cpc == bus.branch_pc) begin
        act = bus.branch_taken ? bus.branch_target : bus.branch_pc + 16'd1;
        bpop = 1;
        if (act != mq[0].pred) begin bmis = 1; tgt = act; end
      end else m_err = 1'b1;
    end
    if (bus.jump_resolved && !bmis) begin
      ji = bpop ? 1 : 0;
      if (mq.size() > ji && mq[ji].cpc == bus.jump_pc) begin
        jpop = 1;
        if (bus.jump_target != mq[ji].pred) begin jmis = 1; tgt = bus.jump_target; end
      end else m_err = 1'b1;
    end
    exp_qfs = bus.is_control && (mq.size() == QD) && !bpop && !jpop;
    if (bmis || jmis) begin
      mq.delete();
      m_pc = tgt;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else begin
      if (bpop) void'(mq.pop_front());
      if (jpop) void'(mq.pop_front());
      if (!bus.stall && !exp_qfs) begin
        if (bus.is_control) mq.push_back('{cpc: m_pc, pred: bus.prediction});
        m_pc = bus.prediction;
      end
    end
    m_flush = bmis || jmis;
    m_flush_ex = bmis;
  endtask

  task automatic drive(input logic st, input logic ic, input logic [W-1:0] pr,
                       input logic br, input logic [W-1:0] bpc, input logic [W-1:0] btgt,
                       input logic btk, input logic jr, input logic [W-1:0] jpc,
                       input logic [W-1:0] jtgt);
    bus.stall = st;
    bus.is_control = ic;
    bus.prediction = pr;
    bus.branch_resolved = br;
    bus.branch_pc = bpc;
    bus.branch_target = btgt;
    bus.branch_taken = btk;
    bus.jump_resolved = jr;
    bus.jump_pc = jpc;
    bus.jump_target = jtgt;
  endtask

  // Called at a negedge with inputs already driven; returns at the following negedge.
  task automatic step();
    bit qfs;
    #1;
    model_step(qfs);
    chk("queue_full_stall", {31'b0, bus.queue_full_stall}, {31'b0, qfs});
    @(posedge clk);
    #1;
    chk("pc", {16'b0, bus.pc}, {16'b0, m_pc});
    chk("flush", {31'b0, bus.flush}, {31'b0, m_flush});
    chk("flush_ex", {31'b0, bus.flush_ex}, {31'b0, m_flush_ex});
    chk("order_error", {31'b0, bus.order_error}, {31'b0, m_err});
    chk("mispredict_count", {16'b0, bus.mispredict_count}, {16'b0, m_cnt});
    @(negedge clk);
  endtask

  function automatic vec_t mkv(input logic st, input logic ic, input logic [W-1:0] pr,
                               input logic br, input logic [W-1:0] bpc, input logic [W-1:0] btgt,
                               input logic btk, input logic jr, input logic [W-1:0] jpc,
                               input logic [W-1:0] jtgt, input logic [W-1:0] e_pc,
                               input logic e_fl, input logic e_flex, input logic [15:0] e_cnt);
    vec_t v;
    v.st = st; v.ic = ic; v.pr = pr; v.br = br; v.bpc = bpc; v.btgt = btgt; v.btk = btk;
    v.jr = jr; v.jpc = jpc; v.jtgt = jtgt; v.e_pc = e_pc; v.e_fl = e_fl; v.e_flex = e_flex;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    vt[0]  = mkv(0, 0, 16'h0001, 0, 0, 0, 0, 0, 0, 0, 16'h0001, 0, 0, 0);
    vt[1]  = mkv(0, 0, 16'h0002, 0, 0, 0, 0, 0, 0, 0, 16'h0002, 0, 0, 0);
    vt[2]  = mkv(0, 0, 16'h0003, 0, 0, 0, 0, 0, 0, 0, 16'h0003, 0, 0, 0);
    vt[3]  = mkv(0, 0, 16'h0004, 0, 0, 0, 0, 0, 0, 0, 16'h0004, 0, 0, 0);
    vt[4]  = mkv(0, 0, 16'h0010, 0, 0, 0, 0, 0, 0, 0, 16'h0010, 0, 0, 0);
    vt[5]  = mkv(0, 1, 16'h0011, 0, 0, 0, 0, 0, 0, 0, 16'h0011, 0, 0, 0);
    vt[6]  = mkv(0, 0, 16'h0012, 1, 16'h0010, 16'h0040, 1, 0, 0, 0, 16'h0040, 1, 1, 1);
    vt[7]  = mkv(0, 0, 16'h0041, 0, 0, 0, 0, 0, 0, 0, 16'h0041, 0, 0, 1);
    vt[8]  = mkv(0, 0, 16'h0020, 0, 0, 0, 0, 0, 0, 0, 16'h0020, 0, 0, 1);
    vt[9]  = mkv(0, 1, 16'h0050, 0, 0, 0, 0, 0, 0, 0, 16'h0050, 0, 0, 1);
    vt[10] = mkv(0, 0, 16'h0051, 0, 0, 0, 0, 1, 16'h0020, 16'h0050, 16'h0051, 0, 0, 1);
    vt[11] = mkv(0, 0, 16'h0008, 0, 0, 0, 0, 0, 0, 0, 16'h0008, 0, 0, 1);
    vt[12] = mkv(0, 1, 16'h0009, 0, 0, 0, 0, 0, 0, 0, 16'h0009, 0, 0, 1);
    vt[13] = mkv(0, 0, 16'h000A, 0, 0, 0, 0, 0, 0, 0, 16'h000A, 0, 0, 1);
    vt[14] = mkv(0, 1, 16'h000B, 0, 0, 0, 0, 0, 0, 0, 16'h000B, 0, 0, 1);
    vt[15] = mkv(0, 0, 16'h000C, 1, 16'h0008, 16'h0030, 1, 1, 16'h000A, 16'h0070, 16'h0030, 1, 1, 2);
    vt[16] = mkv(0, 0, 16'h0031, 0, 0, 0, 0, 0, 0, 0, 16'h0031, 0, 0, 2);
    vt[17] = mkv(0, 1, 16'h0032, 0, 0, 0, 0, 0, 0, 0, 16'h0032, 0, 0, 2);
    vt[18] = mkv(0, 0, 16'h0033, 0, 0, 0, 0, 1, 16'h0031, 16'h0060, 16'h0060, 1, 0, 3);
    vt[19] = mkv(1, 1, 16'h0061, 0, 0, 0, 0, 0, 0, 0, 16'h0060, 0, 0, 3);
    vt[20] = mkv(0, 0, 16'h0061, 0, 0, 0, 0, 0, 0, 0, 16'h0061, 0, 0, 3);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    chk("reset_pc", {16'b0, bus.pc}, 32'h0);
    chk("reset_flush", {31'b0, bus.flush}, 32'h0);
    chk("reset_flush_ex", {31'b0, bus.flush_ex}, 32'h0);
    chk("reset_order_error", {31'b0, bus.order_error}, 32'h0);
    chk("reset_count", {16'b0, bus.mispredict_count}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(vt[i].st, vt[i].ic, vt[i].pr, vt[i].br, vt[i].bpc, vt[i].btgt, vt[i].btk,
            vt[i].jr, vt[i].jpc, vt[i].jtgt);
      step();
      chk($sformatf("vec%0d_pc", i), {16'b0, bus.pc}, {16'b0, vt[i].e_pc});
      chk($sformatf("vec%0d_flush", i), {31'b0, bus.flush}, {31'b0, vt[i].e_fl});
      chk($sformatf("vec%0d_flush_ex", i), {31'b0, bus.flush_ex}, {31'b0, vt[i].e_flex});
      chk($sformatf("vec%0d_count", i), {16'b0, bus.mispredict_count}, {16'b0, vt[i].e_cnt});
    end

    // Fill the queue with four control fetches at 0x61..0x64.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 16'h0062 + 16'(i), 0, 0, 0, 0, 0, 0, 0);
      step();
    end
    chk("filled_pc", {16'b0, bus.pc}, 32'h0065);
    drive(0, 1, 16'h0066, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("full_stall_asserted", {31'b0, bus.queue_full_stall}, 32'h1);
    step();
    chk("full_stall_pc_held", {16'b0, bus.pc}, 32'h0065);
    // Correct not-taken branch frees a slot; the held push goes through at full.
    drive(0, 1, 16'h0066, 1, 16'h0061, 16'h0000, 0, 0, 0, 0);
    #1;
    chk("full_stall_released", {31'b0, bus.queue_full_stall}, 32'h0);
    step();
    chk("push_pop_at_full_pc", {16'b0, bus.pc}, 32'h0066);
    chk("push_pop_no_flush", {31'b0, bus.flush}, 32'h0);

    // Mispredict, then reset while the flush pulse is high.
    drive(0, 0, 16'h0067, 1, 16'h0062, 16'h0099, 1, 0, 0, 0);
    step();
    chk("redirect_pc", {16'b0, bus.pc}, 32'h0099);
    chk("redirect_flush", {31'b0, bus.flush}, 32'h1);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    model_reset();
    chk("async_reset_pc", {16'b0, bus.pc}, 32'h0);
    chk("async_reset_flush", {31'b0, bus.flush}, 32'h0);
    chk("async_reset_flush_ex", {31'b0, bus.flush_ex}, 32'h0);
    chk("async_reset_count", {16'b0, bus.mispredict_count}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 16'h0001, 1, 16'h0062, 16'h0063, 1, 0, 0, 0);
    step();
    chk("empty_queue_order_error", {31'b0, bus.order_error}, 32'h1);
    chk("empty_queue_no_redirect", {16'b0, bus.pc}, 32'h0001);
    drive(0, 0, 16'h0002, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("order_error_sticky", {31'b0, bus.order_error}, 32'h1);

    for (int n = 0; n < 400; n++) begin
      logic [W-1:0] pr, bpc, btgt, jpc, jtgt;
      logic st, ic, br, btk, jr;
      int ji;
      st  = ($urandom_range(0, 99) < 15);
      ic  = ($urandom_range(0, 99) < 45);
      pr  = ($urandom_range(0, 3) == 0) ? W'($urandom) : m_pc + 16'd1;
      br  = ($urandom_range(0, 99) < 30);
      btk = 1'($urandom_range(0, 1));
      if (mq.size() > 0 && $urandom_range(0, 9) != 0) begin
        bpc  = mq[0].cpc;
        btgt = ($urandom_range(0, 4) != 0) ? mq[0].pred : W'($urandom);
      end else begin
        bpc  = W'($urandom);
        btgt = W'($urandom);
      end
      jr = ($urandom_range(0, 99) < 25);
      ji = br ? 1 : 0;
      if (mq.size() > ji && $urandom_range(0, 9) != 0) begin
        jpc  = mq[ji].cpc;
        jtgt = ($urandom_range(0, 4) != 0) ? mq[ji].pred : W'($urandom);
      end else begin
        jpc  = W'($urandom);
        jtgt = W'($urandom);
      end
      drive(st, ic, pr, br, bpc, btgt, btk, jr, jpc, jtgt);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_redirect_unit.md
FETCH_REDIRECT_UNIT -- requirements
Module: fetch_redirect_unit

Interface
REQ-001 Parameter WORD_SIZE, default 16, data/address width.
REQ-002 Parameter QDEPTH, default 4, in-flight control-prediction queue depth (power of two, >=2).
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 stall  in  1  hazard stall from decode; holds fetch PC.
REQ-006 is_control  in  1  predecode: instruction at pc is a jump or branch.
REQ-007 prediction  in  WORD_SIZE  predictor's predicted next PC for pc.
REQ-008 jump_resolved  in  1  jump resolved in ID this cycle.
REQ-009 jump_pc, jump_target  in  WORD_SIZE each  resolved jump address and actual target.
REQ-010 branch_resolved  in  1  branch resolved in EX this cycle.
REQ-011 branch_pc, branch_target  in  WORD_SIZE each  resolved branch address and taken target.
REQ-012 branch_taken  in  1  resolved branch outcome.
REQ-013 pc  out  WORD_SIZE  current fetch address.
REQ-014 flush  out  1  registered; squash IF/ID (and ID/EX on branch mispredict) next cycle.
REQ-015 flush_ex  out  1  registered; asserted with flush only on branch mispredict.
REQ-016 queue_full_stall  out  1  combinational; fetch held because queue full.
REQ-017 order_error  out  1  sticky; resolved PC did not match queue head.
REQ-018 mispredict_count  out  16  saturating count of mispredictions.

Function
REQ-019 Queue entry = {ctrl_pc, predicted_next}; push at fetch of is_control when advancing; pop oldest on each resolution.
REQ-020 Normal advance (no redirect, stall=0, queue_full_stall=0): pc <= prediction; push if is_control.
REQ-021 queue_full_stall = is_control && count==QDEPTH && no pop this cycle; pc holds, no push.
REQ-022 stall=1: pc holds, no push; resolutions still processed.
REQ-023 Actual next: branch = branch_taken ? branch_target : branch_pc+1 (mod 2^WORD_SIZE); jump = jump_target.
REQ-024 Mispredict when actual next != head.predicted_next.
REQ-025 Both resolved same cycle: branch is head, jump is head+1; branch evaluated first.
REQ-026 Branch mispredict: pc <= actual branch next; queue cleared (including jump entry); jump result ignored; flush=flush_ex=1 next cycle.
REQ-027 Branch correct + jump same cycle: pop both; jump mispredict then redirects pc <= jump_target, entries younger than jump cleared, flush=1, flush_ex=0.
REQ-028 Jump-only mispredict: pc <= jump_target; queue cleared past popped entry; flush=1, flush_ex=0.
REQ-029 Redirect overrides stall and queue_full_stall; no push in redirect cycle.
REQ-030 Resolution with empty queue or ctrl_pc != resolved PC: set order_error, pop nothing, no redirect.
REQ-031 Push and pop same cycle permitted at full; count unchanged; pointers wrap modulo QDEPTH.
REQ-032 mispredict_count increments once per redirect (two-event cycle counts at most one), saturates at 16'hFFFF.
REQ-033 flush/flush_ex are single-cycle pulses.

Reset
REQ-034 While reset=1: pc=0, queue empty, flush=flush_ex=0, order_error=0, mispredict_count=0; effective immediately, mid-operation included.
REQ-035 First posedge after reset deassertion fetches from pc=0.

Verification
REQ-036 Sequential: is_control=0, prediction=pc+1 over 5 cycles -> pc 0,1,2,3,4; no flush.
REQ-037 Branch at 0x0010 predicted 0x0011, resolved taken target 0x0040 -> pc=0x0040 next cycle, flush=flush_ex=1 one cycle, count=1, queue empty.
REQ-038 Jump at 0x0020 predicted 0x0050, resolved target 0x0050 -> entry popped, no flush, pc follows prediction.
REQ-039 Four control fetches unresolved, fifth is_control -> queue_full_stall=1, pc held; branch resolves correct -> pop, push proceeds same cycle.
REQ-040 Branch 0x0008 mispredicted and jump 0x000A resolved same cycle -> pc=branch actual, jump ignored, count +1.
REQ-041 reset asserted mid-redirect -> pc=0, flush=0, queue empty without clock edge; branch_resolved with empty queue -> order_error=1 sticky.
